// File: rtl/cbx_cfg_param.sv
// X-channel connection block with pass-through tracks, NUM_IPIN tap muxes and a
// serial configuration chain that commits to the shadow only after an exact-length load.
module cbx_cfg_param #(
  parameter int CHAN_W       = 20,
  parameter int NUM_IPIN     = 9,
  parameter int MUX_SIZE     = 10,
  parameter int TRACK_STRIDE = 4
) (
  input  logic                prog_clk,
  input  logic                pReset,
  input  logic                config_enable,
  input  logic                ccff_head,
  input  logic [CHAN_W-1:0]   chanx_left_in,
  input  logic [CHAN_W-1:0]   chanx_right_in,
  output logic [CHAN_W-1:0]   chanx_left_out,
  output logic [CHAN_W-1:0]   chanx_right_out,
  output logic [NUM_IPIN-1:0] ipin_out,
  output logic                ccff_tail,
  output logic                cfg_active,
  output logic                cfg_done,
  output logic                cfg_err
);

  localparam int SEL_W   = $clog2(MUX_SIZE);
  localparam int TOTAL   = NUM_IPIN * SEL_W;
  localparam int CNT_W   = $clog2(TOTAL + 2);
  localparam int MUX_PAD = 1 << SEL_W;

  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOTAL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(TOTAL + 1);
  localparam logic [SEL_W:0]   SEL_LIM   = (SEL_W + 1)'(MUX_SIZE);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2,
    S_ERR    = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
  logic                r_err, w_err_nxt;
  logic                r_active, r_done;
  logic [TOTAL-1:0]    r_chain, r_shadow;
  logic [MUX_PAD-1:0]  w_mux_in [NUM_IPIN];
  logic [NUM_IPIN-1:0] w_ipin;

  assign chanx_left_out  = chanx_right_in;
  assign chanx_right_out = chanx_left_in;

  // Shift chain and committed shadow; all ones keeps every pin switched off.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_chain  <= '1;
      r_shadow <= '1;
    end else begin
      if (config_enable) begin
        r_chain <= {r_chain[TOTAL-2:0], ccff_head};
      end
      if (r_state == S_COMMIT) begin
        r_shadow <= r_chain;
      end
    end
  end

  // FSM, load counter and status flags.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      r_state  <= S_IDLE;
      r_cnt    <= CNT_ZERO;
      r_err    <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_err    <= w_err_nxt;
      r_active <= (w_state_nxt == S_SHIFT);
      r_done   <= (w_state_nxt == S_COMMIT);
    end
  end

  // Next-state logic; an enable seen in IDLE, COMMIT or ERR always starts a fresh load.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    case (r_state)
      S_SHIFT: begin
        if (config_enable) begin
          w_cnt_nxt = (r_cnt >= CNT_SAT) ? CNT_SAT : r_cnt + CNT_ONE;
        end else if (r_cnt == CNT_TOTAL) begin
          w_state_nxt = S_COMMIT;
          w_cnt_nxt   = CNT_ZERO;
        end else begin
          w_state_nxt = S_ERR;
          w_cnt_nxt   = CNT_ZERO;
          w_err_nxt   = 1'b1;
        end
      end
      S_IDLE, S_COMMIT, S_ERR: begin
        if (config_enable) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = CNT_ONE;
          w_err_nxt   = 1'b0;
        end else begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = CNT_ZERO;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  assign ccff_tail  = r_chain[TOTAL-1];
  assign cfg_active = r_active;
  assign cfg_done   = r_done;
  assign cfg_err    = r_err;

  // Mux input j of pin k taps track (k + (j/2)*TRACK_STRIDE) mod CHAN_W; unused slots read 0.
  for (genvar k = 0; k < NUM_IPIN; k++) begin : g_pin
    for (genvar j = 0; j < MUX_PAD; j++) begin : g_in
      if (j < MUX_SIZE) begin : g_tap
        localparam int T = (k + (j / 2) * TRACK_STRIDE) % CHAN_W;
        if ((j % 2) == 0) begin : g_left
          assign w_mux_in[k][j] = chanx_left_in[T];
        end else begin : g_right
          assign w_mux_in[k][j] = chanx_right_in[T];
        end
      end else begin : g_pad
        assign w_mux_in[k][j] = 1'b0;
      end
    end
  end

  // Pin selection from the committed shadow.
  always_comb begin
    logic [SEL_W-1:0] sel_v;
    w_ipin = '0;
    for (int k = 0; k < NUM_IPIN; k++) begin
      sel_v = r_shadow[k*SEL_W +: SEL_W];
      if ({1'b0, sel_v} < SEL_LIM) begin
        w_ipin[k] = w_mux_in[k][sel_v];
      end else begin
        w_ipin[k] = 1'b0;
      end
    end
  end

  assign ipin_out = w_ipin;

endmodule

// File: tb/tb_cbx_cfg_param.sv
// Directed bench for cbx_cfg_param: vector table for the mux paths plus
// hand-written load sequences for commit, short, over-shift and mid-load reset.
module tb_cbx_cfg_param;

  logic        prog_clk = 1'b0;
  logic        pReset;
  logic        config_enable;
  logic        ccff_head;
  logic [19:0] chanx_left_in, chanx_right_in;
  logic [19:0] chanx_left_out, chanx_right_out;
  logic [8:0]  ipin_out;
  logic        ccff_tail, cfg_active, cfg_done, cfg_err;

  int n_run  = 0;
  int n_fail = 0;

  cbx_cfg_param dut (
    .prog_clk        (prog_clk),
    .pReset          (pReset),
    .config_enable   (config_enable),
    .ccff_head       (ccff_head),
    .chanx_left_in   (chanx_left_in),
    .chanx_right_in  (chanx_right_in),
    .chanx_left_out  (chanx_left_out),
    .chanx_right_out (chanx_right_out),
    .ipin_out        (ipin_out),
    .ccff_tail       (ccff_tail),
    .cfg_active      (cfg_active),
    .cfg_done        (cfg_done),
    .cfg_err         (cfg_err)
  );

  always #5 prog_clk = ~prog_clk;

  typedef struct {
    logic [19:0] left;
    logic [19:0] right;
    logic [8:0]  exp_ipin;
  } vec_t;

  vec_t vecs [7];

  // Config A: pin0 sel=3, others 15.  Config B: pin0 sel=3, pin2 sel=8, others 15.
  localparam logic [35:0] CFG_A = 36'hFFFFFFFF3;
  localparam logic [35:0] CFG_B = 36'hFFFFFF8F3;
  localparam logic [63:0] OVER  = 64'h000000A53C96F00F;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] to_stream(input logic [35:0] cfg);
    logic [63:0] s;
    s = 64'd0;
    for (int i = 0; i < 36; i++) s[i] = cfg[35-i];
    return s;
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic shift_bits(input logic [63:0] s, input int lo, input int hi, input bit hold);
    for (int i = lo; i < hi; i++) begin
      config_enable = 1'b1;
      ccff_head     = s[i];
      tick();
    end
    if (!hold) begin
      config_enable = 1'b0;
      ccff_head     = 1'b0;
    end
  endtask

  task automatic commit_check(input string nm);
    chk({nm, "_active_last"}, 64'(cfg_active), 64'd1);
    tick();
    chk({nm, "_done_pulse"}, 64'(cfg_done), 64'd1);
    tick();
    chk({nm, "_done_clear"}, 64'(cfg_done), 64'd0);
    chk({nm, "_err"}, 64'(cfg_err), 64'd0);
  endtask

  initial begin
    vecs[0] = '{20'h00000, 20'h00000, 9'b000000000};
    vecs[1] = '{20'h00000, 20'h00010, 9'b000000001};
    vecs[2] = '{20'h40000, 20'h00000, 9'b000000100};
    vecs[3] = '{20'h00000, 20'h40000, 9'b000000000};
    vecs[4] = '{20'hFFFFF, 20'hFFFFF, 9'b000000101};
    vecs[5] = '{20'hBFFFF, 20'hFFFEF, 9'b000000000};
    vecs[6] = '{20'h00010, 20'h00000, 9'b000000000};

    pReset        = 1'b1;
    config_enable = 1'b0;
    ccff_head     = 1'b0;
    for (int c = 0; c < 2; c++) begin
      chanx_left_in  = 20'($urandom);
      chanx_right_in = 20'($urandom);
      tick();
      chk("rst_ipin", 64'(ipin_out), 64'd0);
      chk("rst_tail", 64'(ccff_tail), 64'd1);
      chk("rst_err", 64'(cfg_err), 64'd0);
      chk("rst_active", 64'(cfg_active), 64'd0);
      chk("rst_done", 64'(cfg_done), 64'd0);
      chk("rst_left_out", 64'(chanx_left_out), 64'(chanx_right_in));
      chk("rst_right_out", 64'(chanx_right_out), 64'(chanx_left_in));
    end
    pReset = 1'b0;

    // Exact load of config A.
    chanx_left_in  = 20'h00000;
    chanx_right_in = 20'h00000;
    shift_bits(to_stream(CFG_A), 0, 36, 1'b0);
    commit_check("loadA");
    chanx_right_in = 20'h00010;
    #1 chk("A_pin0_hi", 64'(ipin_out), 64'h001);
    chanx_right_in = 20'hFFFEF;
    chanx_left_in  = 20'hFFFFF;
    #1 chk("A_pin0_lo", 64'(ipin_out), 64'h000);

    // Short load of 35 bits: error, no commit, old config kept.
    shift_bits(to_stream(CFG_B), 0, 35, 1'b0);
    tick();
    chk("short_done0", 64'(cfg_done), 64'd0);
    tick();
    chk("short_done1", 64'(cfg_done), 64'd0);
    chk("short_err", 64'(cfg_err), 64'd1);
    chanx_right_in = 20'h00010;
    chanx_left_in  = 20'h40000;
    #1 chk("short_keep", 64'(ipin_out), 64'h001);

    // Full load of B; the error flag clears on the first shift cycle.
    shift_bits(to_stream(CFG_B), 0, 1, 1'b1);
    chk("B_err_clear", 64'(cfg_err), 64'd0);
    chk("B_active", 64'(cfg_active), 64'd1);
    shift_bits(to_stream(CFG_B), 1, 36, 1'b0);
    commit_check("loadB");

    for (int v = 0; v < 7; v++) begin
      chanx_left_in  = vecs[v].left;
      chanx_right_in = vecs[v].right;
      #1;
      chk($sformatf("vec%0d_ipin", v), 64'(ipin_out), 64'(vecs[v].exp_ipin));
      chk($sformatf("vec%0d_lout", v), 64'(chanx_left_out), 64'(vecs[v].right));
      chk($sformatf("vec%0d_rout", v), 64'(chanx_right_out), 64'(vecs[v].left));
    end

    // Over-shift by 4: tail holds stream bit 4, shadow untouched.
    shift_bits(OVER, 0, 40, 1'b0);
    chk("over_tail", 64'(ccff_tail), 64'(OVER[4]));
    chk("over_active", 64'(cfg_active), 64'd1);
    tick();
    chk("over_done0", 64'(cfg_done), 64'd0);
    tick();
    chk("over_err", 64'(cfg_err), 64'd1);
    chk("over_done1", 64'(cfg_done), 64'd0);
    chanx_left_in  = 20'hFFFFF;
    chanx_right_in = 20'hFFFFF;
    #1 chk("over_keep", 64'(ipin_out), 64'h005);

    // Reset after 20 shift cycles.
    shift_bits(to_stream(CFG_A), 0, 20, 1'b1);
    pReset        = 1'b1;
    config_enable = 1'b0;
    tick();
    chk("mid_ipin", 64'(ipin_out), 64'd0);
    chk("mid_active", 64'(cfg_active), 64'd0);
    chk("mid_err", 64'(cfg_err), 64'd0);
    chk("mid_done", 64'(cfg_done), 64'd0);
    chk("mid_tail", 64'(ccff_tail), 64'd1);
    pReset = 1'b0;
    tick();
    chk("mid_idle", 64'(cfg_active), 64'd0);
    shift_bits(to_stream(CFG_A), 0, 36, 1'b0);
    commit_check("reload");
    #1 chk("reload_ipin", 64'(ipin_out), 64'h001);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/cbx_cfg_param.md
Name: cbx_cfg_param

Overview:
- Parametrised X-channel connection block with a built-in configuration-chain controller.
- Channel tracks pass straight through, left to right and right to left.
- NUM_IPIN tap muxes drive grid input pins. Each mux is selected by a committed shadow register.
- The shift chain loads in the background and is committed atomically only after an exact-length load, so pins never glitch during configuration.
- Sits between switch blocks on the I/O row; chained via ccff_head/ccff_tail like every other routing tile.

Parameters:
- CHAN_W, 20, tracks per direction.
- NUM_IPIN, 9, number of grid input pins driven.
- MUX_SIZE, 10, inputs per pin mux. Must be even and ≤ 2*CHAN_W.
- TRACK_STRIDE, 4, track step between successive input pairs of one mux.
- SEL_W (derived localparam), clog2(MUX_SIZE) = 4, select bits per pin.
- TOTAL (derived localparam), NUM_IPIN*SEL_W = 36, chain length.

Ports:
- prog_clk  in  1  sole clock.
- pReset  in  1  synchronous, active-high reset.
- config_enable  in  1  shift enable; high for exactly TOTAL cycles per load.
- ccff_head  in  1  serial config data in.
- chanx_left_in  in  CHAN_W  tracks entering from left.
- chanx_right_in  in  CHAN_W  tracks entering from right.
- chanx_left_out  out  CHAN_W  equals chanx_right_in (combinational).
- chanx_right_out  out  CHAN_W  equals chanx_left_in (combinational).
- ipin_out  out  NUM_IPIN  grid pin drives; bit k is pin k.
- ccff_tail  out  1  chain[TOTAL-1], registered.
- cfg_active  out  1  high in SHIFT state.
- cfg_done  out  1  one-cycle pulse on successful commit.
- cfg_err  out  1  sticky load-length error.

Behaviour:
- Interface: one clock prog_clk; pReset is synchronous and active-high.
- Reset values:
  - chain and shadow all ones.
  - State IDLE; counter 0.
  - cfg_active, cfg_done, cfg_err = 0.
  - ccff_tail = 1.
  - All ipin_out = 0: select value 15 ≥ MUX_SIZE means off.
- Chain, per prog_clk edge with config_enable=1:
  - chain[0] ← ccff_head; chain[i] ← chain[i-1].
  - ccff_tail = chain[TOTAL-1].
  - The first bit shifted ends at chain[TOTAL-1] after TOTAL shifts.
- Select mapping: sel_k[b] = shadow[k*SEL_W + b], b=0 is the LSB. Pin 0 is nearest ccff_head.
- Mux input j of pin k, for j in 0..MUX_SIZE-1:
  - p = j/2.
  - Track t = (k + p*TRACK_STRIDE) mod CHAN_W.
  - j even → chanx_left_in[t]; j odd → chanx_right_in[t].
- Pin output:
  - ipin_out[k] = input[sel_k] if sel_k < MUX_SIZE, else 0.
  - Purely combinational from shadow and channel inputs.
- Counter: increments on each shift cycle and saturates at TOTAL+1. Any value > TOTAL marks an over-shift.
- FSM:
  - IDLE: config_enable=1 → SHIFT. The counter is set to 1, the first bit shifts this cycle, and cfg_err clears.
  - SHIFT, config_enable=1: stay, shift, count.
  - SHIFT, config_enable=0 with count==TOTAL → COMMIT.
  - SHIFT, config_enable=0 with count≠TOTAL → ERR.
  - COMMIT (1 cycle): shadow ← chain; cfg_done=1 this cycle; → IDLE. ipin_out reflects the new config from the next cycle.
  - ERR (1 cycle): shadow unchanged; cfg_err ← 1 (sticky); → IDLE.
  - config_enable=1 during COMMIT or ERR: that cycle still shifts. FSM → SHIFT next cycle with the counter restarting at 1. This load is treated as a new load.
- Reset mid-SHIFT: chain and shadow return to all ones and outputs return to 0. The partial load is discarded and no cfg_err is raised.
- Pass-through channels are unaffected by the FSM and by reset.

Test Plan:
- Reset: assert pReset 2 cycles with random channel inputs → every ipin_out=0, ccff_tail=1, cfg_err=0, and chanx_left_out==chanx_right_in each cycle.
- Exact load, pin 0 sel=3 and all others 15:
  - Shift 36 bits: 32 ones, then 0,0,1,1.
  - Deassert → cfg_done pulses 1 cycle later.
  - Next cycle, ipin_out[0] follows chanx_right_in[4]; ipin_out[1..8]=0.
- Pin 2 sel=8 (p=4): toggle chanx_left_in[(2+16) mod 20]=chanx_left_in[18] → ipin_out[2] toggles. Toggling chanx_right_in[18] has no effect.
- Short load of 35 bits:
  - cfg_err=1, no cfg_done, ipin_out unchanged from previous config.
  - A following 36-bit load clears cfg_err at its first cycle and commits.
- Over-shift: 40 bits → cfg_err=1, shadow unchanged. ccff_tail shows the bit shifted in 36 cycles earlier, i.e. bit 4 of the stream.
- pReset asserted at shift cycle 20 of a load → outputs 0, state IDLE, cfg_err=0. A subsequent full load commits normally.
